debouncer_n: RTL and testbench

DEBOUNCER_N -- requirements
Module: debouncer_n

---
 rtl/debouncer_n.sv | 92 +++++++++
 tb/tb_debouncer_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_n.sv
// N-channel switch debouncer: two-flop synchronizers, a shared sample tick and per-channel
// stability counters; emits registered levels plus one-cycle rise/fall pulses.
module debouncer_n #(
  parameter int unsigned N        = 20,
  parameter int unsigned STABLE   = 4,
  parameter int unsigned TICK_DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CntMax  = CW'(STABLE - 1);

  logic [N-1:0]  sync1_q, sync2_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  dout_d, rise_d, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TickMax);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // A sample equal to the current level restarts the count, so only an unbroken run of
  // STABLE differing ticks can flip the output.
  always_comb begin
    dout_d = dout;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == dout[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_d[i]  = '0;
          dout_d[i] = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      dout <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      dout <= dout_d;
      rise <= rise_d;
      fall <= fall_d;
    end
  end

endmodule

// File: tb/tb_debouncer_n.sv
// Scoreboard bench for debouncer_n: a window-based reference model predicts every cycle,
// a monitor pops and compares; a second instance covers the STABLE=1, TICK_DIV=1 case.
module tb_debouncer_n;

  localparam int N        = 4;
  localparam int STABLE   = 3;
  localparam int TICK_DIV = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] din = '0;
  logic [N-1:0] dout, rise, fall;
  logic [N-1:0] din2 = '0;
  logic [N-1:0] dout2, rise2, fall2;

  debouncer_n #(.N(N), .STABLE(STABLE), .TICK_DIV(TICK_DIV)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
  );

  debouncer_n #(.N(N), .STABLE(1), .TICK_DIV(1)) u_deg (
    .clk  (clk),
    .rst  (rst),
    .din  (din2),
    .dout (dout2),
    .rise (rise2),
    .fall (fall2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [N-1:0] dout;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] dout2;
    logic [N-1:0] rise2;
    logic [N-1:0] fall2;
  } exp_t;

  exp_t exp_q[$];

  // Reference: s is din seen two edges late; ticks fall on every TICK_DIV-th edge after
  // reset; a level flips when the last STABLE tick samples all disagree with it.
  logic [N-1:0] m_s1, m_s2, m_dout;
  logic [N-1:0] samples[$];
  int unsigned  m_edges;
  logic [N-1:0] g_p1, g_p2, g_dout;

  always @(posedge clk) begin : model
    exp_t         e;
    logic [N-1:0] r, f, gr, gf, nd;
    bit           all_diff;
    r  = '0;
    f  = '0;
    gr = '0;
    gf = '0;
    if (rst) begin
      m_s1    = '0;
      m_s2    = '0;
      m_dout  = '0;
      m_edges = 0;
      samples.delete();
      g_p1    = '0;
      g_p2    = '0;
      g_dout  = '0;
    end else begin
      m_edges++;
      if (m_edges % TICK_DIV == 0) begin
        samples.push_back(m_s2);
        if (samples.size() > STABLE) void'(samples.pop_front());
        if (samples.size() == STABLE) begin
          for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < STABLE; k++) begin
              if (samples[k][i] == m_dout[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
              m_dout[i] = ~m_dout[i];
              if (m_dout[i]) r[i] = 1'b1;
              else f[i] = 1'b1;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = din;
      nd     = g_p2;
      gr     = nd & ~g_dout;
      gf     = ~nd & g_dout;
      g_dout = nd;
      g_p2   = g_p1;
      g_p1   = din2;
    end
    e.dout  = m_dout;
    e.rise  = r;
    e.fall  = f;
    e.dout2 = g_dout;
    e.rise2 = gr;
    e.fall2 = gf;
    exp_q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      check("exp_queue_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("dout", dout, e.dout);
      check("rise", rise, e.rise);
      check("fall", fall, e.fall);
      check("deg_dout", dout2, e.dout2);
      check("deg_rise", rise2, e.rise2);
      check("deg_fall", fall2, e.fall2);
    end
  end

  always @(negedge clk) din2 = N'($urandom);

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int waited;
    int ch;
    int rate;
    #1;
    check("reset_dout", dout, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);

    // Press on channel 0
    din[0] = 1'b1;
    waited = 0;
    while (!dout[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("press_latency_le14", 32'(waited <= 14), 32'd1);
    wait_cyc(10);

    // Short glitch on channel 1
    din[1] = 1'b1;
    wait_cyc(6);
    din[1] = 1'b0;
    wait_cyc(20);
    check("glitch_dout1", 32'(dout[1]), 32'd0);

    // Bouncy release on channel 0
    din[0] = 1'b0;
    wait_cyc(4);
    din[0] = 1'b1;
    wait_cyc(4);
    din[0] = 1'b0;
    wait_cyc(30);
    check("release_dout0", 32'(dout[0]), 32'd0);

    // All channels together
    din = '0;
    wait_cyc(30);
    din = '1;
    waited = 0;
    while (rise == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("simul_rise", rise, {N{1'b1}});
    wait_cyc(10);
    check("simul_dout", dout, {N{1'b1}});

    // Reset in the middle of a falling count, din held high through reset
    din = '0;
    wait_cyc(9);
    rst = 1'b1;
    #1;
    check("rst_async_dout", dout, 0);
    check("rst_async_rise", rise, 0);
    check("rst_async_fall", fall, 0);
    din = '1;
    wait_cyc(3);
    rst = 1'b0;
    waited = 0;
    while (rise == '0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("post_reset_rise_edges", waited, 12);
    check("post_reset_rise", rise, {N{1'b1}});
    wait_cyc(5);

    // Random traffic: slow then fast toggling, occasional resets
    for (int phase = 0; phase < 2; phase++) begin
      rate = (phase == 0) ? 7 : 2;
      repeat (1500) begin
        @(negedge clk);
        if ($urandom_range(0, rate) == 0) begin
          ch = int'($urandom_range(0, N - 1));
          din[ch] = ~din[ch];
        end
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
        end
      end
    end

    wait_cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
